// File: rtl/player_move_controller_pkg.sv
// Shared definitions for the tile-movement path: move codes, FSM states and
// tile coordinate type, common to the controller and the collision detector.
package player_move_controller_pkg;

    localparam int COORD_W = 6;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [2:0]         move_t;

    localparam move_t MOVE_NONE  = 3'b000;
    localparam move_t MOVE_UP    = 3'b001;
    localparam move_t MOVE_LEFT  = 3'b010;
    localparam move_t MOVE_DOWN  = 3'b011;
    localparam move_t MOVE_RIGHT = 3'b100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMMIT   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

endpackage

// File: rtl/player_move_controller_if.sv
// Signal bundle between the movement controller and its environment
// (buttons, map loader, collision detector, renderer/game FSM).
interface player_move_controller_if;
    import player_move_controller_pkg::*;

    logic   btn_up;
    logic   btn_down;
    logic   btn_left;
    logic   btn_right;
    logic   load_en;
    coord_t load_x;
    coord_t load_y;
    coord_t det_new_x;
    coord_t det_new_y;
    move_t  move;
    coord_t cur_x;
    coord_t cur_y;
    logic   moved;
    logic   blocked;
    logic   busy;

    // Environment side: buttons, loader and detector drive the controller.
    modport master (
        output btn_up, btn_down, btn_left, btn_right,
        output load_en, load_x, load_y,
        output det_new_x, det_new_y,
        input  move, cur_x, cur_y, moved, blocked, busy
    );

    // Controller side.
    modport slave (
        input  btn_up, btn_down, btn_left, btn_right,
        input  load_en, load_x, load_y,
        input  det_new_x, det_new_y,
        output move, cur_x, cur_y, moved, blocked, busy
    );

endinterface

// File: rtl/player_move_controller_move_arbiter.sv
// Combinational priority encoder: four button levels to one move code,
// priority up > down > left > right.
module player_move_controller_move_arbiter
    import player_move_controller_pkg::*;
(
    input  logic  up,
    input  logic  down,
    input  logic  left,
    input  logic  right,
    output move_t code,
    output logic  any
);

    // Pick the highest-priority pressed button.
    always_comb begin
        code = MOVE_NONE;
        any  = 1'b1;
        if (up) begin
            code = MOVE_UP;
        end else if (down) begin
            code = MOVE_DOWN;
        end else if (left) begin
            code = MOVE_LEFT;
        end else if (right) begin
            code = MOVE_RIGHT;
        end else begin
            code = MOVE_NONE;
            any  = 1'b0;
        end
    end

endmodule

// File: rtl/player_move_controller.sv
// Player movement controller: rate-limits button presses into move requests,
// holds the code for the collision detector, then commits its returned position.
module player_move_controller
    import player_move_controller_pkg::*;
#(
    parameter coord_t START_X       = 6'd1,
    parameter coord_t START_Y       = 6'd2,
    parameter int     SETTLE_CYCLES = 2,
    parameter int     REPEAT_DELAY  = 12500000,
    parameter int     CNT_W         = 24
) (
    input  logic                    clk,
    input  logic                    resetn,
    player_move_controller_if.slave bus
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    move_t            move_r;
    coord_t           cur_x_r;
    coord_t           cur_y_r;
    logic             moved_r;
    logic             blocked_r;
    logic             busy_r;

    move_t            win_move_s;
    logic             any_btn_s;

    player_move_controller_move_arbiter u_arbiter (
        .up    (bus.btn_up),
        .down  (bus.btn_down),
        .left  (bus.btn_left),
        .right (bus.btn_right),
        .code  (win_move_s),
        .any   (any_btn_s)
    );

    // Movement FSM, settle/cooldown counter and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            move_r    <= MOVE_NONE;
            cur_x_r   <= START_X;
            cur_y_r   <= START_Y;
            moved_r   <= 1'b0;
            blocked_r <= 1'b0;
            busy_r    <= 1'b0;
        end else if (bus.load_en) begin
            // Map change wins over everything; any in-flight move is dropped.
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            move_r    <= MOVE_NONE;
            cur_x_r   <= bus.load_x;
            cur_y_r   <= bus.load_y;
            moved_r   <= 1'b0;
            blocked_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            moved_r   <= 1'b0;
            blocked_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_btn_s) begin
                        move_r  <= win_move_s;
                        cnt_r   <= CNT_ZERO;
                        state_r <= ISSUE;
                        busy_r  <= 1'b1;
                    end else begin
                        move_r  <= MOVE_NONE;
                        busy_r  <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Code stays on the detector inputs through COMMIT too.
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == SETTLE_LAST) begin
                        state_r <= COMMIT;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                COMMIT: begin
                    cur_x_r <= bus.det_new_x;
                    cur_y_r <= bus.det_new_y;
                    if ((bus.det_new_x != cur_x_r) || (bus.det_new_y != cur_y_r)) begin
                        moved_r <= 1'b1;
                    end else begin
                        blocked_r <= 1'b1;
                    end
                    move_r  <= MOVE_NONE;
                    cnt_r   <= CNT_ZERO;
                    state_r <= COOLDOWN;
                end
                COOLDOWN: begin
                    move_r <= MOVE_NONE;
                    cnt_r  <= cnt_r + CNT_ONE;
                    // Releasing all buttons cuts the cooldown short.
                    if (!any_btn_s || (cnt_r == REPEAT_LAST)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= COOLDOWN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    move_r  <= MOVE_NONE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.move    = move_r;
    assign bus.cur_x   = cur_x_r;
    assign bus.cur_y   = cur_y_r;
    assign bus.moved   = moved_r;
    assign bus.blocked = blocked_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_player_move_controller.sv
// Self-checking bench for player_move_controller with a stub collision
// detector and a scoreboard of expected committed positions.
module tb_player_move_controller;
    import player_move_controller_pkg::*;

    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
        logic       mv;
    } exp_t;

    logic clk;
    logic resetn;
    logic wall;
    int   passed;
    int   total;
    exp_t sb_q[$];

    player_move_controller_if bus ();

    player_move_controller #(
        .START_X       (6'd1),
        .START_Y       (6'd2),
        .SETTLE_CYCLES (2),
        .REPEAT_DELAY  (8),
        .CNT_W         (24)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub detector: free space steps one tile, a wall returns the same tile.
    always_comb begin
        bus.det_new_x = bus.cur_x;
        bus.det_new_y = bus.cur_y;
        if (!wall) begin
            case (bus.move)
                3'b001:  bus.det_new_y = bus.cur_y - 6'd1;
                3'b010:  bus.det_new_x = bus.cur_x - 6'd1;
                3'b011:  bus.det_new_y = bus.cur_y + 6'd1;
                3'b100:  bus.det_new_x = bus.cur_x + 6'd1;
                default: ;
            endcase
        end
    end

    // Scoreboard monitor: every moved/blocked pulse must match the oldest expectation.
    always begin
        @(posedge clk);
        #1;
        if (bus.moved || bus.blocked) begin
            total++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected_pulse: moved=%0b blocked=%0b cur=(%0d,%0d), required no pulse",
                         bus.moved, bus.blocked, bus.cur_x, bus.cur_y);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({bus.cur_x, bus.cur_y, bus.moved, bus.blocked} !== {e.x, e.y, e.mv, ~e.mv}) begin
                    $display("FAIL sb_result: got cur=(%0d,%0d) moved=%0b blocked=%0b, required cur=(%0d,%0d) moved=%0b blocked=%0b",
                             bus.cur_x, bus.cur_y, bus.moved, bus.blocked, e.x, e.y, e.mv, ~e.mv);
                end else begin
                    passed++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_buttons();
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
    endtask

    task automatic do_load(input logic [5:0] x, input logic [5:0] y);
        bus.load_en = 1'b1;
        bus.load_x  = x;
        bus.load_y  = y;
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_buttons();
        bus.load_en = 1'b0;
        bus.load_x  = 6'd0;
        bus.load_y  = 6'd0;
        wall        = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        total++;
        if ({bus.cur_x, bus.cur_y} !== {6'd1, 6'd2}) begin
            $display("FAIL reset_pos: got (%0d,%0d), required (1,2)", bus.cur_x, bus.cur_y);
        end else begin
            passed++;
        end
        total++;
        if ({bus.move, bus.busy, bus.moved, bus.blocked} !== {3'b000, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_ctrl: got move=%b busy=%b moved=%b blocked=%b, required 000 0 0 0",
                     bus.move, bus.busy, bus.moved, bus.blocked);
        end else begin
            passed++;
        end
    endtask

    task automatic test_single_move();
        bus.btn_right = 1'b1;
        sb_q.push_back('{x: 6'd2, y: 6'd2, mv: 1'b1});
        tick();
        bus.btn_right = 1'b0;
        total++;
        if ({bus.move, bus.busy} !== {3'b100, 1'b1}) begin
            $display("FAIL single_issue0: got move=%b busy=%b, required 100 1", bus.move, bus.busy);
        end else begin
            passed++;
        end
        tick();
        total++;
        if (bus.move !== 3'b100) begin
            $display("FAIL single_issue1: got move=%b, required 100", bus.move);
        end else begin
            passed++;
        end
        tick();
        total++;
        if ({bus.cur_x, bus.cur_y} !== {6'd1, 6'd2}) begin
            $display("FAIL single_early: got (%0d,%0d), required (1,2) before commit", bus.cur_x, bus.cur_y);
        end else begin
            passed++;
        end
        tick();
        total++;
        if ({bus.cur_x, bus.cur_y, bus.move} !== {6'd2, 6'd2, 3'b000}) begin
            $display("FAIL single_commit: got (%0d,%0d) move=%b, required (2,2) move=000",
                     bus.cur_x, bus.cur_y, bus.move);
        end else begin
            passed++;
        end
        tick();
        total++;
        if ({bus.busy, bus.moved} !== {1'b0, 1'b0}) begin
            $display("FAIL single_idle: got busy=%b moved=%b, required 0 0", bus.busy, bus.moved);
        end else begin
            passed++;
        end
    endtask

    task automatic test_blocked();
        do_load(6'd1, 6'd1);
        wall = 1'b1;
        bus.btn_up = 1'b1;
        sb_q.push_back('{x: 6'd1, y: 6'd1, mv: 1'b0});
        repeat (4) tick();
        total++;
        if ({bus.cur_x, bus.cur_y, bus.moved, bus.blocked} !== {6'd1, 6'd1, 1'b0, 1'b1}) begin
            $display("FAIL blocked_result: got (%0d,%0d) moved=%b blocked=%b, required (1,1) 0 1",
                     bus.cur_x, bus.cur_y, bus.moved, bus.blocked);
        end else begin
            passed++;
        end
        bus.btn_up = 1'b0;
        tick();
        wall = 1'b0;
        total++;
        if ({bus.busy, bus.blocked} !== {1'b0, 1'b0}) begin
            $display("FAIL blocked_release: got busy=%b blocked=%b, required 0 0", bus.busy, bus.blocked);
        end else begin
            passed++;
        end
    endtask

    task automatic test_hold_repeat();
        do_load(6'd1, 6'd2);
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{x: 6'd1, y: 6'(3 + k), mv: 1'b1});
        end
        bus.btn_down = 1'b1;
        // One move per 12 cycles: commits land on edges 3, 15, 27, 39.
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((i % 12) == 2) begin
                total++;
                if (bus.cur_y !== 6'(2 + i / 12)) begin
                    $display("FAIL hold_before[%0d]: got y=%0d, required %0d", i, bus.cur_y, 2 + i / 12);
                end else begin
                    passed++;
                end
            end else if ((i % 12) == 3) begin
                total++;
                if (bus.cur_y !== 6'(3 + i / 12)) begin
                    $display("FAIL hold_after[%0d]: got y=%0d, required %0d", i, bus.cur_y, 3 + i / 12);
                end else begin
                    passed++;
                end
            end
        end
        bus.btn_down = 1'b0;
        tick();
        total++;
        if ({bus.busy, bus.move} !== {1'b0, 3'b000}) begin
            $display("FAIL hold_release: got busy=%b move=%b, required 0 000", bus.busy, bus.move);
        end else begin
            passed++;
        end
    endtask

    task automatic test_priority();
        logic [3:0]  btns  [3];
        logic [2:0]  codes [3];
        logic [11:0] posn  [3];
        btns[0]  = 4'b1001; codes[0] = 3'b001; posn[0] = {6'd1, 6'd5};
        btns[1]  = 4'b0111; codes[1] = 3'b011; posn[1] = {6'd1, 6'd6};
        btns[2]  = 4'b0011; codes[2] = 3'b010; posn[2] = {6'd0, 6'd6};
        do_load(6'd1, 6'd6);
        for (int i = 0; i < 3; i++) begin
            {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right} = btns[i];
            sb_q.push_back('{x: posn[i][11:6], y: posn[i][5:0], mv: 1'b1});
            tick();
            clear_buttons();
            total++;
            if (bus.move !== codes[i]) begin
                $display("FAIL priority[%0d]: got move=%b, required %b", i, bus.move, codes[i]);
            end else begin
                passed++;
            end
            repeat (4) tick();
        end
    endtask

    task automatic test_load_mid_move();
        bus.btn_left = 1'b1;
        tick();
        bus.load_en = 1'b1;
        bus.load_x  = 6'd10;
        bus.load_y  = 6'd7;
        tick();
        bus.load_en = 1'b0;
        total++;
        if ({bus.cur_x, bus.cur_y, bus.move, bus.busy, bus.moved, bus.blocked} !==
            {6'd10, 6'd7, 3'b000, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL load_mid: got (%0d,%0d) move=%b busy=%b moved=%b blocked=%b, required (10,7) 000 0 0 0",
                     bus.cur_x, bus.cur_y, bus.move, bus.busy, bus.moved, bus.blocked);
        end else begin
            passed++;
        end
        tick();
        bus.btn_left = 1'b0;
        sb_q.push_back('{x: 6'd9, y: 6'd7, mv: 1'b1});
        total++;
        if ({bus.move, bus.busy} !== {3'b010, 1'b1}) begin
            $display("FAIL load_reissue: got move=%b busy=%b, required 010 1", bus.move, bus.busy);
        end else begin
            passed++;
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        bus.btn_up = 1'b1;
        sb_q.push_back('{x: 6'd9, y: 6'd6, mv: 1'b1});
        repeat (6) tick();
        total++;
        if ({bus.busy, bus.cur_y} !== {1'b1, 6'd6}) begin
            $display("FAIL rstmid_cooldown: got busy=%b y=%0d, required 1 6", bus.busy, bus.cur_y);
        end else begin
            passed++;
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({bus.cur_x, bus.cur_y, bus.move, bus.busy, bus.moved, bus.blocked} !==
            {6'd1, 6'd2, 3'b000, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL rstmid_async: got (%0d,%0d) move=%b busy=%b, required (1,2) 000 0",
                     bus.cur_x, bus.cur_y, bus.move, bus.busy);
        end else begin
            passed++;
        end
        bus.btn_up = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        total++;
        if ({bus.cur_x, bus.cur_y, bus.busy} !== {6'd1, 6'd2, 1'b0}) begin
            $display("FAIL rstmid_after: got (%0d,%0d) busy=%b, required (1,2) 0",
                     bus.cur_x, bus.cur_y, bus.busy);
        end else begin
            passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single_move();
        test_blocked();
        test_hold_repeat();
        test_priority();
        test_load_mid_move();
        test_reset_mid();
        repeat (2) tick();
        total++;
        if (sb_q.size() != 0) begin
            $display("FAIL sb_drain: got %0d outstanding expectations, required 0", sb_q.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
